// File: rtl/tdc_pkg.sv
// rtl/tdc_pkg.sv - shared encodings and constants for the TDC session controller
package tdc_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_WRITE  = 3'd1;
   localparam logic [2:0] ST_SETTLE = 3'd2;
   localparam logic [2:0] ST_FETCH  = 3'd3;
   localparam logic [2:0] ST_SEND   = 3'd4;
   localparam logic [2:0] ST_HDR    = 3'd5;

   localparam logic [31:0] LIMIT_SEL0 = 32'd32;
   localparam logic [31:0] LIMIT_SEL1 = 32'd256;
   localparam logic [31:0] LIMIT_SEL2 = 32'd1024;

   localparam logic [7:0] HDR_BYTE = 8'hA5;

   // Selector 11 means "until FIFO full"; the counter ceiling stands in as its limit.
   function automatic logic [31:0] sel_limit(input logic [1:0] sel, input logic [31:0] max_cnt);
      case (sel)
         2'b00:   sel_limit = LIMIT_SEL0;
         2'b01:   sel_limit = LIMIT_SEL1;
         2'b10:   sel_limit = LIMIT_SEL2;
         default: sel_limit = max_cnt;
      endcase
   endfunction

endpackage

// File: rtl/tdc_byte_serializer.sv
// rtl/tdc_byte_serializer.sv - loads a word and emits its top nbytes bytes MSB-first over valid/ready
module tdc_byte_serializer #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] word,
   input  logic [7:0]   nbytes,
   output logic         tx_valid,
   output logic [7:0]   tx_data,
   input  logic         tx_ready,
   output logic         last
);

   logic [W-1:0] shreg;
   logic [7:0]   remaining;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg     <= '0;
         remaining <= '0;
      end else if (load) begin
         shreg     <= word;
         remaining <= nbytes;
      end else if (tx_valid && tx_ready) begin
         shreg     <= shreg << 8;
         remaining <= remaining - 8'd1;
      end
   end

   // Zeros shift in behind the data, so tx_data returns to 0 once the word is out.
   assign tx_valid = (remaining != 8'd0);
   assign tx_data  = shreg[W-1 -: 8];
   assign last     = tx_valid && tx_ready && (remaining == 8'd1);

endmodule

// File: rtl/tdc_session_ctrl.sv
// rtl/tdc_session_ctrl.sv - one TDC measurement session: gated FIFO writes, then byte drain to UART
// Optional frame header (0xA5, count hi, count lo) when TDC_FRAME_HEADER_EN is defined; needs TS_WIDTH >= 24.
module tdc_session_ctrl
   import tdc_pkg::*;
#(
   parameter int TS_WIDTH   = 32,
   parameter int N_BYTES    = TS_WIDTH / 8,
   parameter int SETTLE_CYC = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_write,
   input  logic                 start_read,
   input  logic [1:0]           selector,
   input  logic                 hit_valid,
   input  logic [TS_WIDTH-1:0]  hit_data,
   input  logic                 fifo_full,
   input  logic                 fifo_empty,
   output logic                 fifo_wr_en,
   output logic [TS_WIDTH-1:0]  fifo_din,
   output logic                 fifo_rd_en,
   input  logic [TS_WIDTH-1:0]  fifo_dout,
   output logic                 tx_valid,
   output logic [7:0]           tx_data,
   input  logic                 tx_ready,
   output logic                 led_write_stage,
   output logic                 led_read_stage,
   output logic                 led_write_err,
   output logic                 led_read_err,
   output logic [CNT_WIDTH-1:0] meas_count
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic [2:0]          state;
   logic [1:0]          sel_q;
   logic [7:0]          settle_cnt;
   logic [1:0]          phase;
   logic                sent_any;
   logic [31:0]         limit;
   logic [31:0]         count_ext;
   logic                can_write;
   logic                hit_last;
   logic                ser_load;
   logic [TS_WIDTH-1:0] ser_word;
   logic [7:0]          ser_nbytes;
   logic                ser_last;

   assign limit     = sel_limit(sel_q, 32'(CNT_MAX));
   assign count_ext = 32'(meas_count);
   // count < limit <= CNT_MAX, so the counter can never wrap: saturation is implicit.
   assign can_write = (state == ST_WRITE) && hit_valid && !fifo_full && (count_ext < limit);
   assign hit_last  = can_write && ((count_ext + 32'd1) == limit);

`ifdef TDC_FRAME_HEADER_EN
   logic [15:0] cnt16;
   assign cnt16 = 16'(meas_count);
`endif

   always_comb begin
      ser_load   = 1'b0;
      ser_word   = '0;
      ser_nbytes = 8'd0;
      if (state == ST_FETCH && phase == 2'd2) begin
         ser_load   = 1'b1;
         ser_word   = fifo_dout;
         ser_nbytes = 8'(N_BYTES);
      end
`ifdef TDC_FRAME_HEADER_EN
      if (state == ST_HDR && phase == 2'd0) begin
         ser_load   = 1'b1;
         ser_word   = TS_WIDTH'({HDR_BYTE, cnt16}) << (TS_WIDTH - 24);
         ser_nbytes = 8'd3;
      end
`endif
   end

   tdc_byte_serializer #(.W(TS_WIDTH)) u_ser (
      .clk      (clk),
      .rst      (rst),
      .load     (ser_load),
      .word     (ser_word),
      .nbytes   (ser_nbytes),
      .tx_valid (tx_valid),
      .tx_data  (tx_data),
      .tx_ready (tx_ready),
      .last     (ser_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_IDLE;
         sel_q         <= 2'b00;
         settle_cnt    <= 8'd0;
         phase         <= 2'd0;
         sent_any      <= 1'b0;
         fifo_wr_en    <= 1'b0;
         fifo_din      <= '0;
         fifo_rd_en    <= 1'b0;
         meas_count    <= '0;
         led_write_err <= 1'b0;
         led_read_err  <= 1'b0;
      end else begin
         fifo_wr_en <= 1'b0;
         fifo_rd_en <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_write) begin
                  state         <= ST_WRITE;
                  meas_count    <= '0;
                  led_write_err <= 1'b0;
                  led_read_err  <= 1'b0;
                  sel_q         <= selector;
               end else if (start_read) begin
                  state      <= ST_SETTLE;
                  settle_cnt <= 8'd0;
                  sent_any   <= 1'b0;
               end
            end
            ST_WRITE: begin
               if (can_write) begin
                  fifo_wr_en <= 1'b1;
                  fifo_din   <= hit_data;
                  meas_count <= meas_count + 1'b1;
               end
               if (hit_valid && fifo_full)
                  led_write_err <= 1'b1;
               if (hit_last || (sel_q == 2'b11 && fifo_full) || start_read) begin
                  state      <= ST_SETTLE;
                  settle_cnt <= 8'd0;
                  sent_any   <= 1'b0;
               end
            end
            ST_SETTLE: begin
               if (settle_cnt == 8'(SETTLE_CYC - 1)) begin
`ifdef TDC_FRAME_HEADER_EN
                  state <= ST_HDR;
`else
                  state <= ST_FETCH;
`endif
                  phase <= 2'd0;
               end else begin
                  settle_cnt <= settle_cnt + 8'd1;
               end
            end
            ST_HDR: begin
               if (phase == 2'd0)
                  phase <= 2'd1;
               else if (ser_last) begin
                  state <= ST_FETCH;
                  phase <= 2'd0;
               end
            end
            ST_FETCH: begin
               // phase 0: check empty / strobe read, 1: FIFO latency, 2: load serializer
               case (phase)
                  2'd0: begin
                     if (fifo_empty) begin
                        state <= ST_IDLE;
                        if (!sent_any)
                           led_read_err <= 1'b1;
                     end else begin
                        fifo_rd_en <= 1'b1;
                        phase      <= 2'd1;
                     end
                  end
                  2'd1: phase <= 2'd2;
                  default: begin
                     state    <= ST_SEND;
                     sent_any <= 1'b1;
                     phase    <= 2'd0;
                  end
               endcase
            end
            ST_SEND: begin
               if (ser_last)
                  state <= ST_FETCH;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign led_write_stage = (state == ST_WRITE);
   assign led_read_stage  = (state == ST_SETTLE) || (state == ST_FETCH) ||
                            (state == ST_SEND)   || (state == ST_HDR);

endmodule

// File: tb/tb_tdc_session_ctrl.sv
// tb/tb_tdc_session_ctrl.sv - directed self-checking bench for tdc_session_ctrl
// Honours TDC_FRAME_HEADER_EN to expect the frame header bytes.
module tb_tdc_session_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_write = 1'b0;
   logic        start_read = 1'b0;
   logic [1:0]  selector = 2'b00;
   logic        hit_valid = 1'b0;
   logic [31:0] hit_data = '0;
   logic        fifo_full = 1'b0;
   logic        fifo_empty = 1'b1;
   logic        fifo_wr_en;
   logic [31:0] fifo_din;
   logic        fifo_rd_en;
   logic [31:0] fifo_dout = '0;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready = 1'b1;
   logic        led_write_stage;
   logic        led_read_stage;
   logic        led_write_err;
   logic        led_read_err;
   logic [15:0] meas_count;

   int checks = 0;
   int failures = 0;
   logic [7:0]  rx[$];
   logic [7:0]  exp_q[$];
   logic [31:0] fq[$];
   int wr_cnt = 0;
   int rd_cnt = 0;
   int rx_base = 0;

   tdc_session_ctrl dut (
      .clk(clk), .rst(rst), .start_write(start_write), .start_read(start_read),
      .selector(selector), .hit_valid(hit_valid), .hit_data(hit_data),
      .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_wr_en(fifo_wr_en),
      .fifo_din(fifo_din), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .led_write_stage(led_write_stage), .led_read_stage(led_read_stage),
      .led_write_err(led_write_err), .led_read_err(led_read_err),
      .meas_count(meas_count)
   );

   always #5 clk = ~clk;

   // FIFO model with one-cycle read latency, plus UART byte capture
   always @(posedge clk) begin
      if (tx_valid && tx_ready) rx.push_back(tx_data);
      if (fifo_rd_en) begin
         rd_cnt++;
         if (fq.size() > 0) fifo_dout <= fq.pop_front();
      end
      if (fifo_wr_en) begin
         wr_cnt++;
         fq.push_back(fifo_din);
      end
      fifo_empty <= (fq.size() == 0);
   end

   function automatic logic [31:0] hit_word(input int i);
      logic [7:0] b;
      b = 8'(i);
      return {b, 8'hC3, b ^ 8'h5A, 8'h3C};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic add_word(input logic [31:0] w);
      for (int b = 0; b < 4; b++) exp_q.push_back(w[31-8*b -: 8]);
   endtask

   task automatic add_hdr(input logic [15:0] c);
`ifdef TDC_FRAME_HEADER_EN
      exp_q.push_back(8'hA5);
      exp_q.push_back(c[15:8]);
      exp_q.push_back(c[7:0]);
`else
      if (c === 16'hxxxx) exp_q.delete();
`endif
   endtask

   task automatic pulse_write;
      start_write = 1'b1;
      tick;
      start_write = 1'b0;
   endtask

   task automatic pulse_read;
      start_read = 1'b1;
      tick;
      start_read = 1'b0;
   endtask

   task automatic test_reset;
      logic [62:0] outs;
      rst = 1'b1;
      repeat (3) tick;
      outs = {tx_valid, tx_data, fifo_wr_en, fifo_rd_en, fifo_din, meas_count,
              led_write_stage, led_read_stage, led_write_err, led_read_err};
      checks++;
      if (outs !== '0) begin
         failures++;
         $display("FAIL reset_outputs got=%h want=0", outs);
      end
      rst = 1'b0;
      tick;
      checks++;
      if (led_write_stage !== 1'b0 || led_read_stage !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle got w=%b r=%b want 0 0", led_write_stage, led_read_stage);
      end
   endtask

   task automatic test_write_limit;
      int w0;
      w0 = wr_cnt;
      rx_base = rx.size();
      exp_q.delete();
      add_hdr(16'd32);
      for (int i = 0; i < 32; i++) add_word(hit_word(i));
      selector = 2'b00;
      pulse_write;
      for (int i = 0; i < 300; i++) begin
         hit_valid = 1'b1;
         hit_data  = hit_word(i);
         tick;
         hit_valid = 1'b0;
         if (i == 30) begin
            checks++;
            if (led_write_stage !== 1'b1 || meas_count !== 16'd31) begin
               failures++;
               $display("FAIL t1_before_limit got w=%b cnt=%0d want 1 31", led_write_stage, meas_count);
            end
         end
         if (i == 31) begin
            checks++;
            if (led_write_stage !== 1'b0 || led_read_stage !== 1'b1 || meas_count !== 16'd32) begin
               failures++;
               $display("FAIL t1_settle_at_limit got w=%b r=%b cnt=%0d want 0 1 32",
                        led_write_stage, led_read_stage, meas_count);
            end
         end
         repeat (14) tick;
      end
      checks++;
      if (wr_cnt - w0 != 32) begin
         failures++;
         $display("FAIL t1_write_pulses got=%0d want=32", wr_cnt - w0);
      end
      checks++;
      if (meas_count !== 16'd32 || led_write_err !== 1'b0) begin
         failures++;
         $display("FAIL t1_count_err got cnt=%0d werr=%b want 32 0", meas_count, led_write_err);
      end
   endtask

   task automatic test_read_drain;
      int bad;
      int off;
      logic [31:0] first;
      bad = 0;
`ifdef TDC_FRAME_HEADER_EN
      off = 3;
`else
      off = 0;
`endif
      checks++;
      if (rx.size() - rx_base != exp_q.size()) begin
         failures++;
         $display("FAIL t2_byte_count got=%0d want=%0d", rx.size() - rx_base, exp_q.size());
      end
      first = '0;
      if (rx.size() >= rx_base + off + 4)
         first = {rx[rx_base+off], rx[rx_base+off+1], rx[rx_base+off+2], rx[rx_base+off+3]};
      checks++;
      if (first !== hit_word(0)) begin
         failures++;
         $display("FAIL t2_first_word got=%h want=%h", first, hit_word(0));
      end
      for (int i = 0; i < exp_q.size() && rx_base + i < rx.size(); i++)
         if (rx[rx_base+i] !== exp_q[i]) bad++;
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL t2_byte_values got=%0d wrong bytes want=0", bad);
      end
      checks++;
      if (led_read_stage !== 1'b0 || led_write_stage !== 1'b0 || led_read_err !== 1'b0) begin
         failures++;
         $display("FAIL t2_idle got r=%b w=%b rerr=%b want 0 0 0", led_read_stage, led_write_stage, led_read_err);
      end
   endtask

   task automatic test_fifo_full;
      int w0;
      int n;
      w0 = wr_cnt;
      rx_base = rx.size();
      selector = 2'b11;
      pulse_write;
      for (int i = 0; i < 5; i++) begin
         hit_valid = 1'b1;
         hit_data  = hit_word(100 + i);
         tick;
         hit_valid = 1'b0;
         repeat (2) tick;
      end
      fifo_full = 1'b1;
      hit_valid = 1'b1;
      hit_data  = 32'hDEAD_BEEF;
      tick;
      hit_valid = 1'b0;
      checks++;
      if (led_write_err !== 1'b1 || led_write_stage !== 1'b0 || meas_count !== 16'd5) begin
         failures++;
         $display("FAIL t3_full got werr=%b w=%b cnt=%0d want 1 0 5", led_write_err, led_write_stage, meas_count);
      end
      checks++;
      if (wr_cnt - w0 != 5) begin
         failures++;
         $display("FAIL t3_writes got=%0d want=5", wr_cnt - w0);
      end
      n = 0;
      while ((led_read_stage || led_write_stage) && n < 500) begin
         tick;
         n++;
      end
      fifo_full = 1'b0;
      checks++;
      if (led_read_stage !== 1'b0 || rx.size() - rx_base != 20 + ((exp_q.size() - 128) % 4)) begin
         failures++;
         $display("FAIL t3_drain got r=%b bytes=%0d want 0 20+hdr", led_read_stage, rx.size() - rx_base);
      end
   endtask

   task automatic test_empty_read;
      int n;
      bit seen_valid;
      n = 0;
      seen_valid = 0;
      rx_base = rx.size();
      pulse_read;
      while (led_read_stage && n < 60) begin
         if (tx_valid) seen_valid = 1;
         tick;
         n++;
      end
`ifdef TDC_FRAME_HEADER_EN
      checks++;
      if (rx.size() - rx_base != 3 || rx[rx_base] !== 8'hA5 || rx[rx_base+1] !== 8'h00 || rx[rx_base+2] !== 8'h05) begin
         failures++;
         $display("FAIL t4_header got %0d bytes want A5 00 05", rx.size() - rx_base);
      end
`else
      checks++;
      if (n != 5) begin
         failures++;
         $display("FAIL t4_read_cycles got=%0d want=5", n);
      end
      checks++;
      if (seen_valid || rx.size() != rx_base) begin
         failures++;
         $display("FAIL t4_no_tx got valid_seen=%0d bytes=%0d want 0 0", seen_valid, rx.size() - rx_base);
      end
`endif
      checks++;
      if (led_read_err !== 1'b1 || led_read_stage !== 1'b0) begin
         failures++;
         $display("FAIL t4_read_err got rerr=%b r=%b want 1 0", led_read_err, led_read_stage);
      end
   endtask

   task automatic test_backpressure;
      int n;
      int bad;
      int r0;
      logic [7:0] d0;
      rx_base = rx.size();
      exp_q.delete();
      add_hdr(16'd2);
      add_word(32'h1122_3344);
      add_word(32'h5566_7788);
      selector = 2'b00;
      tx_ready = 1'b1;
      pulse_write;
      hit_valid = 1'b1; hit_data = 32'h1122_3344; tick; hit_valid = 1'b0;
      repeat (2) tick;
      hit_valid = 1'b1; hit_data = 32'h5566_7788; tick; hit_valid = 1'b0;
      tick;
      pulse_read;
      n = 0;
      while (rx.size() < rx_base + 2 && n < 200) begin
         tick;
         n++;
      end
      tx_ready = 1'b0;
      d0 = tx_data;
      r0 = rd_cnt;
      checks++;
      if (tx_valid !== 1'b1 || d0 !== exp_q[2]) begin
         failures++;
         $display("FAIL t5_stall_byte got v=%b d=%h want 1 %h", tx_valid, d0, exp_q[2]);
      end
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick;
         if (tx_valid !== 1'b1 || tx_data !== d0) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL t5_stable got=%0d unstable cycles want=0", bad);
      end
      checks++;
      if (rd_cnt != r0) begin
         failures++;
         $display("FAIL t5_no_read got=%0d reads want=0", rd_cnt - r0);
      end
      tx_ready = 1'b1;
      n = 0;
      while (led_read_stage && n < 200) begin
         tick;
         n++;
      end
      bad = 0;
      for (int i = 0; i < exp_q.size() && rx_base + i < rx.size(); i++)
         if (rx[rx_base+i] !== exp_q[i]) bad++;
      checks++;
      if (bad != 0 || rx.size() - rx_base != exp_q.size()) begin
         failures++;
         $display("FAIL t5_bytes got=%0d bytes %0d wrong want=%0d 0", rx.size() - rx_base, bad, exp_q.size());
      end
   endtask

   task automatic test_reset_mid_send;
      int n;
      int r0;
      int w0;
      logic [62:0] outs;
      selector = 2'b00;
      pulse_write;
      hit_valid = 1'b1; hit_data = 32'hCAFE_F00D; tick; hit_valid = 1'b0;
      tx_ready = 1'b0;
      pulse_read;
      n = 0;
      while (!tx_valid && n < 100) begin
         tick;
         n++;
      end
      checks++;
      if (tx_valid !== 1'b1) begin
         failures++;
         $display("FAIL t6_reach_send got v=%b want 1", tx_valid);
      end
      #2 rst = 1'b1;
      #1;
      outs = {tx_valid, tx_data, fifo_wr_en, fifo_rd_en, fifo_din, meas_count,
              led_write_stage, led_read_stage, led_write_err, led_read_err};
      checks++;
      if (outs !== '0) begin
         failures++;
         $display("FAIL t6_async_reset got=%h want=0", outs);
      end
      tick;
      rst = 1'b0;
      r0 = rd_cnt;
      w0 = wr_cnt;
      tx_ready = 1'b1;
      repeat (5) tick;
      checks++;
      if (rd_cnt != r0 || wr_cnt != w0 || tx_valid !== 1'b0) begin
         failures++;
         $display("FAIL t6_quiet got rd=%0d wr=%0d v=%b want 0 0 0", rd_cnt - r0, wr_cnt - w0, tx_valid);
      end
      start_write = 1'b1;
      start_read  = 1'b1;
      tick;
      start_write = 1'b0;
      start_read  = 1'b0;
      checks++;
      if (led_write_stage !== 1'b1 || led_read_stage !== 1'b0) begin
         failures++;
         $display("FAIL t6_write_wins got w=%b r=%b want 1 0", led_write_stage, led_read_stage);
      end
      hit_valid = 1'b1; hit_data = 32'h0BAD_CAFE; tick; hit_valid = 1'b0;
      checks++;
      if (meas_count !== 16'd1 || fifo_wr_en !== 1'b1 || fifo_din !== 32'h0BAD_CAFE) begin
         failures++;
         $display("FAIL t6_write_after got cnt=%0d we=%b din=%h want 1 1 0badcafe", meas_count, fifo_wr_en, fifo_din);
      end
   endtask

   initial begin
      test_reset;
      test_write_limit;
      test_read_drain;
      test_fifo_full;
      test_empty_read;
      test_backpressure;
      test_reset_mid_send;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
